// File: rtl/mem_phase_checker.sv
// Phase-driven memory write/read-back checker: one LOAD/WRITE/READ/CHECK per address,
// pass/fail reporting per full pass, and recovery from a broken phase sequence.
module mem_phase_checker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned SEED   = 32'h0000_00A5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic              en,
    input  logic              inj,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              done,
    output logic              pass_ok,
    output logic              seq_err
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] SEED_W   = DATA_W'(SEED);
    localparam logic [1:0]        PH_LOAD  = 2'b00;
    localparam logic [1:0]        PH_WRITE = 2'b01;
    localparam logic [1:0]        PH_READ  = 2'b10;
    localparam logic [1:0]        PH_CHECK = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } mode_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wdata_r;
    logic              par;
    logic              pass_err;
    logic [1:0]        prev_state;
    mode_t             mode;

    logic              legal_c;
    logic              act_c;
    logic              mem_we_c;
    logic              miss_c;
    logic [DATA_W-1:0] pat_c;

    // Phase decode; a 00 sample always acts so HOLD exits straight into LOAD
    always_comb begin
        legal_c  = (state == prev_state + 2'd1);
        act_c    = en && ((state == PH_LOAD) || ((mode == RUN) && legal_c));
        mem_we_c = rst && act_c && (state == PH_WRITE);
        miss_c   = (rdata != wdata_r);
        pat_c    = DATA_W'(addr) ^ SEED_W ^ {DATA_W{par}};
    end

    // Test memory, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[addr] <= wdata_r ^ DATA_W'(inj);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr           <= '0;
            rdata          <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass_ok        <= 1'b0;
            seq_err        <= 1'b0;
            wdata_r        <= '0;
            par            <= 1'b0;
            pass_err       <= 1'b0;
            prev_state     <= PH_CHECK;
            mode           <= RUN;
        end else begin
            prev_state <= state;
            done       <= 1'b0;
            if (en) begin
                mode <= act_c ? RUN : HOLD;
                if ((mode == RUN) && !legal_c) begin
                    seq_err <= 1'b1;
                end
                if (act_c) begin
                    case (state)
                        PH_LOAD:  wdata_r <= pat_c;
                        PH_WRITE: ;
                        PH_READ:  rdata <= mem[addr];
                        PH_CHECK: begin
                            if (miss_c) begin
                                if (err_cnt != 8'hFF) begin
                                    err_cnt <= err_cnt + 8'd1;
                                end
                                if (err_cnt == 8'd0) begin
                                    first_err_addr <= addr;
                                end
                            end
                            addr <= addr + ADDR_W'(1);
                            // Last address closes the pass and flips the pattern polarity
                            if (&addr) begin
                                done     <= 1'b1;
                                pass_ok  <= !(pass_err || miss_c);
                                par      <= ~par;
                                pass_err <= 1'b0;
                            end else if (miss_c) begin
                                pass_err <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_phase_checker.sv
// Directed bench for mem_phase_checker with hand-computed expectations.
module tb_mem_phase_checker;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    logic       en;
    logic       inj;
    logic [3:0] addr;
    logic [7:0] rdata;
    logic [7:0] err_cnt;
    logic [3:0] first_err_addr;
    logic       done;
    logic       pass_ok;
    logic       seq_err;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] ph     = 2'b00;
    int         n;

    mem_phase_checker dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .en             (en),
        .inj            (inj),
        .addr           (addr),
        .rdata          (rdata),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .done           (done),
        .pass_ok        (pass_ok),
        .seq_err        (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one phase value and sample just after the edge that consumes it
    task automatic cyc(input logic [1:0] s);
        @(negedge clk);
        state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc(ph);
        ph = ph + 2'd1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_to_done(input string tag, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!done && cnt < 300);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        state = 2'b00;
        en    = 1'b1;
        inj   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr",    32'(addr),           32'd0);
        chk("rst_rdata",   32'(rdata),          32'd0);
        chk("rst_err",     32'(err_cnt),        32'd0);
        chk("rst_first",   32'(first_err_addr), 32'd0);
        chk("rst_done",    32'(done),           32'd0);
        chk("rst_passok",  32'(pass_ok),        32'd0);
        chk("rst_seqerr",  32'(seq_err),        32'd0);
        #1 rst = 1'b1;

        // Pass 1: clean, done lands on the 64th edge
        ph = 2'b00;
        run_to_done("p1", n);
        chk("p1_cycles", 32'(n),       32'd64);
        chk("p1_passok", 32'(pass_ok), 32'd1);
        chk("p1_err",    32'(err_cnt), 32'd0);
        chk("p1_addr",   32'(addr),    32'd0);
        chk("p1_seqerr", 32'(seq_err), 32'd0);

        // Pass 2: inverted pattern, addr 0 reads 00^A5^FF = 5A
        step();
        chk("p2_done_pulse", 32'(done), 32'd0);
        steps(2);
        chk("p2_rdata0", 32'(rdata), 32'h5A);
        step();
        chk("p2_addr1", 32'(addr), 32'd1);
        run_to_done("p2", n);
        chk("p2_cycles", 32'(n),       32'd60);
        chk("p2_passok", 32'(pass_ok), 32'd1);

        // Pass 3: single injected fault at addr 3 (pattern A6, written A7)
        steps(12);
        step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        step();
        chk("inj_rdata", 32'(rdata), 32'hA7);
        step();
        chk("inj_err",   32'(err_cnt),        32'd1);
        chk("inj_first", 32'(first_err_addr), 32'd3);
        run_to_done("p3", n);
        chk("p3_passok", 32'(pass_ok), 32'd0);
        chk("p3_err",    32'(err_cnt), 32'd1);
        run_to_done("p4", n);
        chk("p4_passok", 32'(pass_ok), 32'd1);
        chk("p4_err",    32'(err_cnt), 32'd1);

        // Pass 5: freeze for 10 cycles after the READ of addr 7 (07^A5 = A2)
        steps(28);
        steps(3);
        chk("frz_rdata_pre", 32'(rdata), 32'hA2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("frz_addr",  32'(addr),    32'd7);
            chk("frz_err",   32'(err_cnt), 32'd1);
            chk("frz_rdata", 32'(rdata),   32'hA2);
            chk("frz_done",  32'(done),    32'd0);
        end
        en = 1'b1;
        run_to_done("p5", n);
        chk("p5_passok", 32'(pass_ok), 32'd1);
        chk("p5_seqerr", 32'(seq_err), 32'd0);
        chk("p5_err",    32'(err_cnt), 32'd1);

        // Pass 6: broken sequence 00,01,11,11,00 at addr 2
        steps(8);
        cyc(2'b00);
        cyc(2'b01);
        cyc(2'b11);
        chk("seq_flag",  32'(seq_err), 32'd1);
        chk("seq_addr",  32'(addr),    32'd2);
        chk("seq_err",   32'(err_cnt), 32'd1);
        cyc(2'b11);
        chk("hold_addr", 32'(addr),    32'd2);
        cyc(2'b00);
        ph = 2'b01;
        run_to_done("p6", n);
        chk("p6_cycles", 32'(n),       32'd55);
        chk("p6_passok", 32'(pass_ok), 32'd1);
        chk("p6_seqerr", 32'(seq_err), 32'd1);

        // Pass 7: asynchronous reset during the WRITE cycle of addr 7
        steps(29);
        @(negedge clk);
        state = ph;
        rst   = 1'b0;
        #1;
        chk("arst_addr",   32'(addr),           32'd0);
        chk("arst_rdata",  32'(rdata),          32'd0);
        chk("arst_err",    32'(err_cnt),        32'd0);
        chk("arst_first",  32'(first_err_addr), 32'd0);
        chk("arst_passok", 32'(pass_ok),        32'd0);
        chk("arst_seqerr", 32'(seq_err),        32'd0);
        chk("arst_done",   32'(done),           32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        ph = 2'b00;
        run_to_done("prst", n);
        chk("prst_cycles", 32'(n),       32'd64);
        chk("prst_passok", 32'(pass_ok), 32'd1);
        chk("prst_err",    32'(err_cnt), 32'd0);

        // Saturation: every word corrupted for 17 passes
        inj = 1'b1;
        run_to_done("sat1", n);
        chk("sat1_err",    32'(err_cnt),        32'd16);
        chk("sat1_first",  32'(first_err_addr), 32'd0);
        chk("sat1_passok", 32'(pass_ok),        32'd0);
        for (int p = 0; p < 16; p++) run_to_done("satn", n);
        chk("sat_err",    32'(err_cnt),        32'd255);
        chk("sat_first",  32'(first_err_addr), 32'd0);
        chk("sat_passok", 32'(pass_ok),        32'd0);
        inj = 1'b0;
        run_to_done("clean", n);
        chk("clean_passok", 32'(pass_ok), 32'd1);
        chk("clean_err",    32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_phase_checker.md
# mem_phase_checker

Phase-driven memory write/read-back checker for the memory integration design. It consumes the free-running 2-bit phase count (00→01→10→11) produced by the next-state counter and runs one load/write/read/compare operation per address on an internal DEPTH-word memory. It walks every address, then reports pass/fail, an error count and the first failing address. It also detects and recovers from a broken phase sequence.

## Interface
- DATA_W, 8, memory word width
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
- SEED, 8'hA5, pattern seed (low DATA_W bits used)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- state  in  2  phase from next-state counter
- en  in  1  1 = act on phase; 0 = freeze
- inj  in  1  fault inject: flips bit 0 of data written in WRITE phase
- addr  out  ADDR_W  current test address
- rdata  out  DATA_W  last word read from memory
- err_cnt  out  8  mismatch count, saturating at 255
- first_err_addr  out  ADDR_W  address of first mismatch since reset
- done  out  1  one-cycle pulse at end of each full pass
- pass_ok  out  1  result of last completed pass; held until next done
- seq_err  out  1  sticky phase-sequence error

## Operation
- All actions happen on the rising clk edge that samples `state` with en=1.
- Pattern: pat(a) = zero_ext(a) ^ SEED ^ {DATA_W{par}}. `par` toggles at each done, so stale words from the previous pass miscompare.
- Phase 00, LOAD: wdata_r <= pat(addr).
- Phase 01, WRITE: mem[addr] <= wdata_r ^ {0…0,inj}.
- Phase 10, READ: rdata <= mem[addr].
- Phase 11, CHECK:
  - On rdata != wdata_r: err_cnt++ (saturating), and first_err_addr <= addr if no earlier mismatch.
  - addr <= addr+1, wrapping DEPTH-1→0.
  - At addr==DEPTH-1: done<=1, pass_ok <= (no mismatch in this pass), par toggles, and the per-pass mismatch flag clears.
- Sequence tracking: prev_state register, reset value 2'b11.
  - A legal sample is state == prev_state+1 (mod 4).
  - On an illegal sample: seq_err<=1 (sticky), and the block enters HOLD.
  - In HOLD, no memory, addr, counter or check updates occur.
  - HOLD exits on the edge that samples state==00. That edge performs a normal LOAD, so the interrupted address is redone from the start.
- prev_state <= state on every edge, regardless of en or HOLD.
- en=0: all registers except prev_state are frozen. done is forced to 0. No seq_err is raised on resume if the counter kept running.
- Reset: addr, rdata, err_cnt, first_err_addr, done, pass_ok, seq_err, wdata_r, par and the pass mismatch flag all go to 0; prev_state goes to 2'b11. Memory array contents are not reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- One address takes 4 cycles. A full pass takes 4·DEPTH cycles (64 at defaults).
- rdata is valid the cycle after the READ edge. addr advances the cycle after the CHECK edge.
- done goes high the cycle after the CHECK edge of address DEPTH-1, for exactly 1 cycle. pass_ok updates in that same cycle.
- err_cnt at 255 stays at 255.
- A mismatch at the last address is counted and is included in that pass's pass_ok.
- rst assertion mid-pass clears outputs immediately (asynchronously). The first operation after release is LOAD at addr 0, when the counter presents 00.
- Two done pulses are separated by at least 4·DEPTH cycles.

## Test plan
- Reset, then counter free-running with en=1 and inj=0 for 64 cycles:
  - done pulses once, 64 cycles after the first LOAD edge.
  - pass_ok=1, err_cnt=0, addr=0, seq_err=0.
  - During pass 2, rdata at addr 0 = 8'h5A (par=1).
- inj=1 only during the WRITE edge of addr 3:
  - err_cnt=1, first_err_addr=3.
  - At done, pass_ok=0.
  - The next clean pass gives pass_ok=1 with err_cnt still 1.
- Drive state 00,01,11,11,00:
  - seq_err=1 on the 11 edge.
  - No addr/err_cnt change.
  - LOAD resumes at the same addr on the 00 edge, and a subsequent clean pass gives pass_ok=1.
- inj=1 held for 17 passes (272 mismatches): err_cnt saturates at 255, first_err_addr=0.
- en=0 for 10 cycles mid-pass at addr 7 while the counter runs: addr, err_cnt and rdata are frozen, no seq_err, and the pass completes with pass_ok=1.
- rst low at addr 7 mid-WRITE: all outputs are 0 within the same cycle, and after release the pass restarts at addr 0 and completes 64 cycles later.
